// File: rtl/edf_urgency_tracker.sv
// Per-queue aged-urgency tracker feeding a max-discriminant selector tree, with a grant/hold FSM.
// Optional out_starved port is enabled by defining URGENCY_STARVATION_FLAG_EN.
module edf_urgency_tracker #(
    parameter int NB_QUEUES         = 4,
    parameter int VALUE_SIZE        = 2,
    parameter int DISCRIMINANT_SIZE = 4,
    parameter int TICK_PERIOD       = 8,
    parameter int HOLD_CYCLES       = 3
) (
    input  logic                                   clk,
    input  logic                                   resetn,
    input  logic [NB_QUEUES-1:0]                   in_request,
    output logic [NB_QUEUES*VALUE_SIZE-1:0]        out_values,
    output logic [NB_QUEUES*DISCRIMINANT_SIZE-1:0] out_discriminants,
    input  logic                                   in_grant_valid,
    input  logic [VALUE_SIZE-1:0]                  in_grant_value,
    output logic                                   out_grant_ready,
    output logic                                   out_grant_error
`ifdef URGENCY_STARVATION_FLAG_EN
    ,
    output logic [NB_QUEUES-1:0]                   out_starved
`endif
);

    localparam int PRESC_W = (TICK_PERIOD > 1) ? $clog2(TICK_PERIOD) : 1;
    localparam int HOLD_W  = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    typedef enum logic [0:0] {
        ST_READY = 1'b0,
        ST_HOLD  = 1'b1
    } state_t;

    typedef logic [DISCRIMINANT_SIZE-1:0] urgency_t;

    state_t                state;
    logic [HOLD_W-1:0]     hold_cnt;
    logic [VALUE_SIZE-1:0] frozen_id;
    logic [PRESC_W-1:0]    presc;
    urgency_t              urgency      [NB_QUEUES];
    urgency_t              urgency_next [NB_QUEUES];

    logic                  tick;
    logic                  handshake;
    logic                  grant_legal;
    logic                  hold_active;
    logic [NB_QUEUES-1:0]  grant_hit;
    logic [NB_QUEUES-1:0]  freeze;

    assign tick        = (presc == PRESC_W'(TICK_PERIOD - 1));
    assign handshake   = in_grant_valid & out_grant_ready;
    assign hold_active = (state == ST_HOLD) && (hold_cnt != '0);

    // Legality is decoded per queue instead of a magnitude compare, so it stays
    // correct when NB_QUEUES fills the whole index range.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        grant_hit = '0;
        for (int i = 0; i < NB_QUEUES; i++) begin
            grant_hit[i] = (in_grant_value == VALUE_SIZE'(i));
        end
        grant_legal = |grant_hit;
    end

    // A queue is frozen both in the cycle its grant lands and while the hold
    // countdown is non-zero; the last HOLD cycle already lets it restart at 1.
    always_comb begin
        freeze = '0;
        for (int i = 0; i < NB_QUEUES; i++) begin
            freeze[i] = (handshake & grant_hit[i]) |
                        (hold_active & (frozen_id == VALUE_SIZE'(i)));
        end
    end

    always_comb begin
        for (int i = 0; i < NB_QUEUES; i++) begin
            urgency_next[i] = urgency[i];
            if (freeze[i] || !in_request[i]) begin
                urgency_next[i] = '0;
            end else if (urgency[i] == '0) begin
                urgency_next[i] = urgency_t'(1);
            end else if (tick && (urgency[i] != '1)) begin
                urgency_next[i] = urgency[i] + urgency_t'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            presc <= '0;
        end else if (tick) begin
            // NOTE: sequential state uses non-blocking assignments only.
            presc <= '0;
        end else begin
            presc <= presc + PRESC_W'(1);
        end
    end

    // Counters are a handful of flops, not a RAM, so they take the async reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < NB_QUEUES; i++) urgency[i] <= '0;
        end else begin
            for (int i = 0; i < NB_QUEUES; i++) urgency[i] <= urgency_next[i];
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state           <= ST_READY;
            hold_cnt        <= '0;
            frozen_id       <= '0;
            out_grant_ready <= 1'b1;
            out_grant_error <= 1'b0;
        end else begin
            out_grant_error <= handshake & ~grant_legal;
            case (state)
                ST_READY: begin
                    if (handshake && grant_legal) begin
                        frozen_id       <= in_grant_value;
                        hold_cnt        <= HOLD_W'(HOLD_CYCLES - 1);
                        state           <= ST_HOLD;
                        out_grant_ready <= 1'b0;
                    end
                end
                ST_HOLD: begin
                    if (hold_cnt == '0) begin
                        state           <= ST_READY;
                        out_grant_ready <= 1'b1;
                    end else begin
                        hold_cnt <= hold_cnt - HOLD_W'(1);
                    end
                end
                default: begin
                    state           <= ST_READY;
                    out_grant_ready <= 1'b1;
                end
            endcase
        end
    end

    for (genvar g = 0; g < NB_QUEUES; g++) begin : g_out
        assign out_values[g*VALUE_SIZE +: VALUE_SIZE]               = VALUE_SIZE'(g);
        assign out_discriminants[g*DISCRIMINANT_SIZE +: DISCRIMINANT_SIZE] = urgency[g];
    end

`ifdef URGENCY_STARVATION_FLAG_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            out_starved <= '0;
        end else begin
            for (int i = 0; i < NB_QUEUES; i++) out_starved[i] <= (urgency_next[i] == '1);
        end
    end
`endif

endmodule

// File: doc/edf_urgency_tracker.md
Name: edf_urgency_tracker

Overview:
- Feeds the tournament reduction tree of max-discriminant selectors. Supplies one (value, discriminant) pair per queue:
  - value = queue index
  - discriminant = aged urgency
- Consumes the tree's winning value through a valid/ready grant handshake. On grant it resets the winner's urgency and holds it out of arbitration while its transaction is in flight.
- Sits between the per-queue request logic and the selector tree in the relational cache arbitration path.

Parameters:
- NB_QUEUES, 4, number of tracked queues (≥2).
- VALUE_SIZE, 2, width of queue index, ≥ clog2(NB_QUEUES).
- DISCRIMINANT_SIZE, 4, width of urgency counter.
- TICK_PERIOD, 8, clock cycles per aging tick (≥1).
- HOLD_CYCLES, 3, cycles the granted queue stays frozen after acceptance (≥1).

Ports:
- clk  input  1  clock; all state on rising edge.
- resetn  input  1  reset, asynchronous, active-low.
- in_request  input  NB_QUEUES  per-queue pending flag, level.
- out_values  output  NB_QUEUES*VALUE_SIZE  flat; slice i = i, constant.
- out_discriminants  output  NB_QUEUES*DISCRIMINANT_SIZE  flat; slice i = urgency of queue i.
- in_grant_valid  input  1  tree presents a winner.
- in_grant_value  input  VALUE_SIZE  winning queue index.
- out_grant_ready  output  1  tracker can accept a grant.
- out_grant_error  output  1  one-cycle pulse on an illegal grant.

Behaviour:
- Reset (async assert, sync-safe deassert): all of the following are 0.
  - urgency counters, prescaler, hold counter, out_discriminants, out_grant_error.
  - out_grant_ready = 1; FSM = READY; out_values are constants.
- Prescaler:
  - Counts 0..TICK_PERIOD-1, free-running.
  - A tick fires in the cycle the count equals TICK_PERIOD-1, then wraps to 0.
- Urgency per queue i, all outputs registered, 1-cycle latency from inputs:
  - in_request[i]=0: counter ← 0.
  - Request rising while counter=0 and queue not frozen: counter ← 1 (pending always beats idle).
  - Tick, pending, not frozen: counter ← counter+1, saturating at 2^DISCRIMINANT_SIZE-1 (no wrap).
  - Frozen queue: counter forced to 0 regardless of request or tick.
- FSM states: READY, HOLD.
  - READY:
    - out_grant_ready=1.
    - Handshake = in_grant_valid & out_grant_ready.
    - On handshake with in_grant_value < NB_QUEUES: latch index as frozen_id, counter[frozen_id] ← 0 next cycle, hold counter ← HOLD_CYCLES-1, go to HOLD.
    - On handshake with in_grant_value ≥ NB_QUEUES: out_grant_error pulses next cycle, no counter change, stay READY.
    - Grant to a queue whose in_request=0 is legal: freezes normally, no error.
  - HOLD:
    - out_grant_ready=0; in_grant_valid is ignored.
    - Hold counter decrements each cycle. At 0, go to READY and unfreeze.
    - Total frozen cycles = HOLD_CYCLES.
    - After unfreezing, a still-high request restarts at 1 on the first READY cycle.
- Simultaneous events:
  - Tick and handshake in the same cycle: granted queue → 0, other pending queues age.
  - Request drop and tick in the same cycle: counter → 0.
- Reset asserted mid-HOLD: immediate return to the reset state. No grant is remembered.
- in_grant_value must be stable only during the handshake cycle.

Optional Feature:
- Macro URGENCY_STARVATION_FLAG_EN.
- Defined:
  - Extra output out_starved, NB_QUEUES wide.
  - Bit i is registered high while counter[i] is saturated, cleared together with the counter; reset value 0.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
- Reset with in_request=4'b1111, resetn low for 3 cycles, then released.
  - During reset: all discriminants 0, ready=1, error=0.
  - One cycle after release: all discriminants 1.
- Aging with TICK_PERIOD=8, request[2] held high from t=0.
  - Discriminant[2] reaches 2 after the first tick.
  - It saturates at 15 after 14 ticks and stays 15 (no wrap).
  - With the macro defined, starved[2]=1 from that point.
- Grant handshake with valid=1, value=2 in READY.
  - ready=0 for exactly 3 cycles; discriminant[2]=0 throughout.
  - Then ready=1 and discriminant[2]=1 (request still high).
  - A grant presented during HOLD is not accepted.
- Illegal grant with NB_QUEUES=3, VALUE_SIZE=2, grant value=3.
  - error pulses for exactly 1 cycle; FSM stays READY; no discriminant changes.
- Simultaneous tick and grant to queue 1 while queues 0 and 1 are at 5.
  - Next cycle: queue 0 = 6, queue 1 = 0.
- Reset mid-HOLD: assert resetn low during the second HOLD cycle.
  - ready=1 and all counters 0 asynchronously, before the next clock edge.
